// File: rtl/vinstr_queue.sv
// Elastic FWFT queue between the scalar vector-dispatch port and vector decode.
// Buffers 96-bit packets and tracks occupancy plus the number of queued vset instructions.
module vinstr_queue #(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned DATA_FROM_SCALAR = 96
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [DATA_FROM_SCALAR-1:0] instr_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [DATA_FROM_SCALAR-1:0] instr_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic [$clog2(DEPTH+1)-1:0]  vset_cnt_o,
  output logic                        head_vset_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Explicit wrap compare keeps non-power-of-2 depths correct.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic [DATA_FROM_SCALAR-1:0] mem_q       [DEPTH];
  logic                        vset_flag_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  cnt_t vset_cnt_q, vset_cnt_d;

  logic push, pop, in_vset, head_vset;

  assign in_vset = (instr_i[70:64] == 7'b1010111) && (instr_i[78:76] == 3'b111);

  assign valid_o     = (count_q != '0);
  assign ready_o     = (count_q != cnt_t'(DEPTH)) && !flush_i;
  assign push        = valid_i && ready_o;
  assign pop         = valid_o && ready_i;
  assign head_vset   = vset_flag_q[rd_ptr_q] && valid_o;
  assign head_vset_o = head_vset;
  assign instr_o     = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;
  assign vset_cnt_o  = vset_cnt_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    vset_cnt_d = vset_cnt_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      vset_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
      case ({push && in_vset, pop && head_vset})
        2'b10:   vset_cnt_d = vset_cnt_q + cnt_t'(1);
        2'b01:   vset_cnt_d = vset_cnt_q - cnt_t'(1);
        default: vset_cnt_d = vset_cnt_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vset_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      vset_cnt_q <= vset_cnt_d;
    end
  end

  // NOTE: storage has no reset; entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]       <= instr_i;
      vset_flag_q[wr_ptr_q] <= in_vset;
    end
  end

endmodule

// File: tb/tb_vinstr_queue.sv
// Directed bench for vinstr_queue: vector table for single-cycle behaviour,
// hand sequences for wrap, reset mid-operation and a DEPTH=3 random-throttle run.
module tb_vinstr_queue;

  localparam logic [31:0] VSETVLI = 32'h00D7_7057;
  localparam logic [31:0] VADD    = 32'h0200_0057;
  localparam logic [95:0] Z       = '0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [95:0] instr_i = '0;
  logic        ready_o, valid_o, head_vset_o;
  logic [95:0] instr_o;
  logic [2:0]  count_o, vset_cnt_o;

  logic        v3 = 1'b0, r3 = 1'b0;
  logic [95:0] i3 = '0;
  logic        ready3, valid3, head3;
  logic [95:0] instr3;
  logic [1:0]  count3, vset3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  vinstr_queue #(.DEPTH(4), .DATA_FROM_SCALAR(96)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o),
    .count_o(count_o), .vset_cnt_o(vset_cnt_o), .head_vset_o(head_vset_o)
  );

  vinstr_queue #(.DEPTH(3), .DATA_FROM_SCALAR(96)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
    .valid_i(v3), .ready_o(ready3), .instr_i(i3),
    .valid_o(valid3), .ready_i(r3), .instr_o(instr3),
    .count_o(count3), .vset_cnt_o(vset3), .head_vset_o(head3)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [95:0] vs(input int n);
    return {VSETVLI, 32'h0, 32'(n)};
  endfunction

  function automatic logic [95:0] va(input int n);
    return {VADD, 32'(n) + 32'h100, 32'(n)};
  endfunction

  typedef struct {
    logic        v, r, f;
    logic [95:0] pkt;
    logic        e_valid, e_ready;
    logic [2:0]  e_cnt, e_vset;
    logic        e_head;
    logic [95:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic v, r, f, input logic [95:0] pkt,
                              input logic ev, er, input int ec, evs, input logic eh,
                              input logic [95:0] ei);
    vec_t t;
    t.v = v; t.r = r; t.f = f; t.pkt = pkt;
    t.e_valid = ev; t.e_ready = er; t.e_cnt = 3'(ec); t.e_vset = 3'(evs);
    t.e_head = eh; t.e_instr = ei;
    return t;
  endfunction

  task automatic check_state(input string tag, input logic ev, er, input int ec, evs,
                             input logic eh, input logic [95:0] ei);
    check({tag, ".valid_o"},     valid_o,     ev);
    check({tag, ".ready_o"},     ready_o,     er);
    check({tag, ".count_o"},     count_o,     96'(ec));
    check({tag, ".vset_cnt_o"},  vset_cnt_o,  96'(evs));
    check({tag, ".head_vset_o"}, head_vset_o, eh);
    check({tag, ".instr_o"},     instr_o,     ei);
  endtask

  // Protocol monitor on the DEPTH=4 instance, sampled mid-low-phase.
  logic        hold_q = 1'b0;
  logic [95:0] held_q = '0;
  always @(negedge rst_n) hold_q = 1'b0;
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (count_o == 3'd4 && valid_i) check("mon.no_push_full", ready_o, 1'b0);
      if (count_o == 3'd0 && ready_i) check("mon.no_pop_empty", valid_o, 1'b0);
      if (hold_q) check("mon.instr_stable", instr_o, held_q);
      if (vset_cnt_o > count_o) check("mon.vset_le_count", vset_cnt_o, count_o);
      hold_q = valid_o && !ready_i && !flush_i;
      held_q = instr_o;
    end
  end

  vec_t tbl[28];
  logic [95:0] q3[$];

  initial begin
    // Tests 1, 2, 4, 5: each row is one cycle; expectations are pre-edge outputs.
    tbl[0]  = mk(1, 0, 0, vs(20), 0, 1, 0, 0, 0, Z);
    tbl[1]  = mk(0, 1, 0, Z,      1, 1, 1, 1, 1, vs(20));
    tbl[2]  = mk(1, 0, 0, va(1),  0, 1, 0, 0, 0, Z);
    tbl[3]  = mk(1, 0, 0, va(2),  1, 1, 1, 0, 0, va(1));
    tbl[4]  = mk(1, 0, 0, va(3),  1, 1, 2, 0, 0, va(1));
    tbl[5]  = mk(1, 0, 0, va(4),  1, 1, 3, 0, 0, va(1));
    tbl[6]  = mk(1, 0, 0, va(5),  1, 0, 4, 0, 0, va(1));
    tbl[7]  = mk(1, 0, 0, va(5),  1, 0, 4, 0, 0, va(1));
    tbl[8]  = mk(1, 0, 0, va(5),  1, 0, 4, 0, 0, va(1));
    tbl[9]  = mk(0, 1, 0, Z,      1, 0, 4, 0, 0, va(1));
    tbl[10] = mk(0, 1, 0, Z,      1, 1, 3, 0, 0, va(2));
    tbl[11] = mk(0, 1, 0, Z,      1, 1, 2, 0, 0, va(3));
    tbl[12] = mk(0, 1, 0, Z,      1, 1, 1, 0, 0, va(4));
    tbl[13] = mk(0, 0, 0, Z,      0, 1, 0, 0, 0, Z);
    tbl[14] = mk(1, 0, 0, vs(1),  0, 1, 0, 0, 0, Z);
    tbl[15] = mk(1, 0, 0, va(6),  1, 1, 1, 1, 1, vs(1));
    tbl[16] = mk(1, 0, 0, vs(2),  1, 1, 2, 1, 1, vs(1));
    tbl[17] = mk(0, 1, 0, Z,      1, 1, 3, 2, 1, vs(1));
    tbl[18] = mk(0, 1, 0, Z,      1, 1, 2, 1, 0, va(6));
    tbl[19] = mk(0, 0, 0, Z,      1, 1, 1, 1, 1, vs(2));
    tbl[20] = mk(1, 0, 0, va(7),  1, 1, 1, 1, 1, vs(2));
    tbl[21] = mk(1, 0, 0, va(8),  1, 1, 2, 1, 1, vs(2));
    tbl[22] = mk(1, 0, 1, vs(3),  1, 0, 3, 1, 1, vs(2));
    tbl[23] = mk(0, 0, 0, Z,      0, 1, 0, 0, 0, Z);
    tbl[24] = mk(1, 0, 0, va(9),  0, 1, 0, 0, 0, Z);
    tbl[25] = mk(0, 0, 0, Z,      1, 1, 1, 0, 0, va(9));
    tbl[26] = mk(0, 1, 0, Z,      1, 1, 1, 0, 0, va(9));
    tbl[27] = mk(0, 0, 0, Z,      0, 1, 0, 0, 0, Z);

    #2;
    check_state("reset", 0, 1, 0, 0, 0, Z);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      valid_i = tbl[i].v; ready_i = tbl[i].r; flush_i = tbl[i].f; instr_i = tbl[i].pkt;
      #1;
      check_state($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_ready,
                  int'(tbl[i].e_cnt), int'(tbl[i].e_vset), tbl[i].e_head, tbl[i].e_instr);
    end

    // Test 3: steady count 2 with push and pop every cycle across pointer wrap.
    @(negedge clk); valid_i = 1'b1; ready_i = 1'b0; instr_i = va(100);
    @(negedge clk); instr_i = va(101);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); valid_i = 1'b1; ready_i = 1'b1; instr_i = va(102 + k);
      #1;
      check($sformatf("stream%0d.count", k), count_o, 96'd2);
      check($sformatf("stream%0d.instr", k), instr_o, va(100 + k));
    end
    @(negedge clk); valid_i = 1'b0; ready_i = 1'b1; #1;
    check("drain0.instr", instr_o, va(110));
    @(negedge clk); #1;
    check("drain1.instr", instr_o, va(111));
    check("drain1.count", count_o, 96'd1);
    @(negedge clk); ready_i = 1'b0; #1;
    check("drain2.count", count_o, 96'd0);

    // Test 6: asynchronous reset mid-cycle with three entries queued.
    @(negedge clk); valid_i = 1'b1; instr_i = vs(7);
    @(negedge clk); instr_i = va(8);
    @(negedge clk); instr_i = va(9);
    @(negedge clk); valid_i = 1'b0; #1;
    check_state("pre_rst", 1, 1, 3, 1, 1, vs(7));
    #1 rst_n = 1'b0;
    #1 check_state("mid_rst", 0, 1, 0, 0, 0, Z);
    @(negedge clk); rst_n = 1'b1; valid_i = 1'b1; instr_i = va(10);
    @(negedge clk); valid_i = 1'b0; #1;
    check_state("post_rst", 1, 1, 1, 0, 0, va(10));
    @(negedge clk); ready_i = 1'b1;
    @(negedge clk); ready_i = 1'b0;

    // Test 7: DEPTH=3 instance, 20 packets at random throttle against a queue model.
    begin
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic push_m, pop_m;
      while (got < 20 && cyc < 500) begin
        @(negedge clk);
        v3 = (sent < 20) && ($urandom_range(0, 1) == 1);
        r3 = ($urandom_range(0, 2) != 0);
        i3 = va(200 + sent);
        #1;
        check("d3.count", count3, 96'(q3.size()));
        check("d3.ready", ready3, q3.size() < 3);
        check("d3.valid", valid3, q3.size() != 0);
        if (q3.size() != 0) check("d3.instr", instr3, q3[0]);
        push_m = v3 && (q3.size() < 3);
        pop_m  = r3 && (q3.size() != 0);
        @(posedge clk);
        if (pop_m) begin void'(q3.pop_front()); got++; end
        if (push_m) begin q3.push_back(i3); sent++; end
        cyc++;
      end
      check("d3.all_popped", 96'(got), 96'd20);
      @(negedge clk); v3 = 1'b0; r3 = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
